// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: turns raw PS/2 Set-2 bytes into key events.
// Tracks prefixes (E0 extended, F0 break, E1 discarded), shift/caps state,
// the last held key and a make-event counter.
// Optional build macro: PS2_TYPEMATIC_FILTER_EN suppresses auto-repeat makes
// of the currently held key (no event, no count, no caps toggle).
module ps2_scancode_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       scan_data,
  input  logic             scan_ready,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_break,
  output logic             key_ext,
  output logic [7:0]       key_ascii,
  output logic             key_down,
  output logic [7:0]       held_code,
  output logic             shift_on,
  output logic             caps_on,
  output logic [CNT_W-1:0] press_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  state_t           state_r, state_next_s;
  logic             ev_fire_s, ev_break_s, ev_ext_s;
  logic             typematic_s, ev_accept_s, ev_make_s, upper_s;
  logic [7:0]       ev_ascii_s;
  logic             key_valid_r, key_break_r, key_ext_r, key_down_r;
  logic             lshift_r, rshift_r, caps_r, held_ext_r;
  logic [7:0]       key_code_r, key_ascii_r, held_code_r;
  logic [CNT_W-1:0] press_count_r;

  // Set-2 make code to ASCII; letters shifted to upper case when requested.
  function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic upper);
    logic [7:0] letter;
    logic [7:0] other;
    case (code)
      8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;  8'h21: letter = 8'h63;
      8'h23: letter = 8'h64;  8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
      8'h34: letter = 8'h67;  8'h33: letter = 8'h68;  8'h43: letter = 8'h69;
      8'h3B: letter = 8'h6A;  8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;  8'h44: letter = 8'h6F;
      8'h4D: letter = 8'h70;  8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
      8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;  8'h3C: letter = 8'h75;
      8'h2A: letter = 8'h76;  8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
      8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
      default: letter = 8'h00;
    endcase
    case (code)
      8'h45: other = 8'h30;  8'h16: other = 8'h31;  8'h1E: other = 8'h32;
      8'h26: other = 8'h33;  8'h25: other = 8'h34;  8'h2E: other = 8'h35;
      8'h36: other = 8'h36;  8'h3D: other = 8'h37;  8'h3E: other = 8'h38;
      8'h46: other = 8'h39;  8'h29: other = 8'h20;  8'h5A: other = 8'h0D;
      8'h66: other = 8'h08;
      default: other = 8'h00;
    endcase
    if (letter != 8'h00) begin
      ascii_of = upper ? (letter - 8'h20) : letter;
    end else begin
      ascii_of = other;
    end
  endfunction

  // Prefix state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Prefix decoding: next state and whether this byte completes an event.
  always_comb begin
    state_next_s = state_r;
    ev_fire_s    = 1'b0;
    ev_break_s   = 1'b0;
    ev_ext_s     = 1'b0;
    if (scan_ready) begin
      case (state_r)
        ST_IDLE: begin
          case (scan_data)
            8'hE0:   state_next_s = ST_EXT;
            8'hF0:   state_next_s = ST_BRK;
            8'hE1:   state_next_s = ST_IDLE;
            default: ev_fire_s    = 1'b1;
          endcase
        end
        ST_EXT: begin
          case (scan_data)
            8'hF0:   state_next_s = ST_EXT_BRK;
            8'hE0:   state_next_s = ST_EXT;
            default: begin
              ev_fire_s    = 1'b1;
              ev_ext_s     = 1'b1;
              state_next_s = ST_IDLE;
            end
          endcase
        end
        ST_BRK: begin
          case (scan_data)
            8'hE0:   state_next_s = ST_EXT_BRK;
            8'hF0:   state_next_s = ST_BRK;
            default: begin
              ev_fire_s    = 1'b1;
              ev_break_s   = 1'b1;
              state_next_s = ST_IDLE;
            end
          endcase
        end
        ST_EXT_BRK: begin
          case (scan_data)
            8'hE0, 8'hF0: state_next_s = ST_EXT_BRK;
            default: begin
              ev_fire_s    = 1'b1;
              ev_break_s   = 1'b1;
              ev_ext_s     = 1'b1;
              state_next_s = ST_IDLE;
            end
          endcase
        end
        default: state_next_s = ST_IDLE;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  assign typematic_s = ev_fire_s && !ev_break_s && key_down_r &&
                       (scan_data == held_code_r) && (ev_ext_s == held_ext_r);
`else
  assign typematic_s = 1'b0;
`endif

  assign ev_accept_s = ev_fire_s && !typematic_s;
  assign ev_make_s   = ev_accept_s && !ev_break_s;
  // Case selection uses modifier state from before the current event.
  assign upper_s     = (lshift_r | rshift_r) ^ caps_r;

  // ASCII only for plain (non-extended) make events.
  always_comb begin
    ev_ascii_s = 8'h00;
    if (ev_break_s || ev_ext_s) begin
      ev_ascii_s = 8'h00;
    end else begin
      ev_ascii_s = ascii_of(scan_data, upper_s);
    end
  end

  // Event output registers; fields hold until the next accepted event.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      key_valid_r <= 1'b0;
      key_code_r  <= 8'h00;
      key_break_r <= 1'b0;
      key_ext_r   <= 1'b0;
      key_ascii_r <= 8'h00;
    end else begin
      key_valid_r <= ev_accept_s;
      if (ev_accept_s) begin
        key_code_r  <= scan_data;
        key_break_r <= ev_break_s;
        key_ext_r   <= ev_ext_s;
        key_ascii_r <= ev_ascii_s;
      end
    end
  end

  // Shift and caps-lock state, updated by non-extended modifier codes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lshift_r <= 1'b0;
      rshift_r <= 1'b0;
      caps_r   <= 1'b0;
    end else if (ev_accept_s && !ev_ext_s) begin
      if (scan_data == 8'h12) lshift_r <= !ev_break_s;
      if (scan_data == 8'h59) rshift_r <= !ev_break_s;
      if ((scan_data == 8'h58) && !ev_break_s) caps_r <= !caps_r;
    end
  end

  // Held-key tracker and make-event counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      key_down_r    <= 1'b0;
      held_code_r   <= 8'h00;
      held_ext_r    <= 1'b0;
      press_count_r <= {CNT_W{1'b0}};
    end else if (ev_make_s) begin
      key_down_r    <= 1'b1;
      held_code_r   <= scan_data;
      held_ext_r    <= ev_ext_s;
      press_count_r <= press_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (ev_accept_s && (scan_data == held_code_r) && (ev_ext_s == held_ext_r)) begin
      key_down_r <= 1'b0;
    end
  end

  assign key_valid   = key_valid_r;
  assign key_code    = key_code_r;
  assign key_break   = key_break_r;
  assign key_ext     = key_ext_r;
  assign key_ascii   = key_ascii_r;
  assign key_down    = key_down_r;
  assign held_code   = held_code_r;
  assign shift_on    = lshift_r | rshift_r;
  assign caps_on     = caps_r;
  assign press_count = press_count_r;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: expected events are queued
// when their final byte is driven and compared when key_valid appears.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] scan_data = 8'h00;
  logic       scan_ready = 1'b0;
  logic       key_valid, key_break, key_ext, key_down, shift_on, caps_on;
  logic [7:0] key_code, key_ascii, held_code, press_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [17:0] exp_q[$];
  logic [7:0]  exp_count = 8'h00;

  ps2_scancode_decoder #(.CNT_W(8)) dut (
    .clk(clk), .resetn(resetn), .scan_data(scan_data), .scan_ready(scan_ready),
    .key_valid(key_valid), .key_code(key_code), .key_break(key_break),
    .key_ext(key_ext), .key_ascii(key_ascii), .key_down(key_down),
    .held_code(held_code), .shift_on(shift_on), .caps_on(caps_on),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Queue an expected event; makes advance the expected counter.
  task automatic expect_ev(input logic [7:0] code, input logic brk, input logic ext,
                           input logic [7:0] ascii);
    exp_q.push_back({code, brk, ext, ascii});
    if (!brk) exp_count = exp_count + 8'd1;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    scan_data  = b;
    scan_ready = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    scan_ready = 1'b0;
  endtask

  // Event monitor: every key_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_event: observed code %h break %b, expected no event",
               key_code, key_break);
      end
      if (exp_q.size() != 0) begin
        check("event", {14'd0, key_code, key_break, key_ext, key_ascii}, {14'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {key_valid, key_code, key_break, key_ext, key_ascii, key_down,
                            held_code, shift_on, caps_on}, 32'd0);
    check("reset_count", {24'd0, press_count}, 32'd0);
    resetn = 1'b1;

    // Plain make
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h61); send(8'h1C); idle();
    check("make_down", {23'd0, key_down, held_code}, {23'd0, 1'b1, 8'h1C});
    check("make_count", {24'd0, press_count}, {24'd0, exp_count});

    // Break; no event on F0 alone
    send(8'hF0); expect_ev(8'h1C, 1'b1, 1'b0, 8'h00); send(8'h1C); idle();
    check("break_down", {31'd0, key_down}, 32'd0);
    check("break_count", {24'd0, press_count}, {24'd0, exp_count});

    // Shift upper-cases letters
    expect_ev(8'h12, 1'b0, 1'b0, 8'h00); send(8'h12);
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h41); send(8'h1C); idle();
    check("shift_set", {31'd0, shift_on}, 32'd1);
    send(8'hF0); expect_ev(8'h1C, 1'b1, 1'b0, 8'h00); send(8'h1C);
    send(8'hF0); expect_ev(8'h12, 1'b1, 1'b0, 8'h00); send(8'h12); idle();
    check("shift_clear", {31'd0, shift_on}, 32'd0);
    check("shift_count", {24'd0, press_count}, {24'd0, exp_count});

    // Caps lock toggles; shift XOR caps
    expect_ev(8'h58, 1'b0, 1'b0, 8'h00); send(8'h58);
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h41); send(8'h1C); idle();
    check("caps_set", {31'd0, caps_on}, 32'd1);
    expect_ev(8'h59, 1'b0, 1'b0, 8'h00); send(8'h59);
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h61); send(8'h1C); idle();
    check("rshift_set", {31'd0, shift_on}, 32'd1);
    send(8'hF0); expect_ev(8'h59, 1'b1, 1'b0, 8'h00); send(8'h59);
    send(8'hF0); expect_ev(8'h58, 1'b1, 1'b0, 8'h00); send(8'h58); idle();
    check("caps_break_hold", {30'd0, caps_on, shift_on}, {30'd0, 1'b1, 1'b0});
    expect_ev(8'h58, 1'b0, 1'b0, 8'h00); send(8'h58); idle();
    check("caps_toggle_off", {31'd0, caps_on}, 32'd0);
    send(8'hF0); expect_ev(8'h58, 1'b1, 1'b0, 8'h00); send(8'h58); idle();

    // Digits and specials, back-to-back
    expect_ev(8'h12, 1'b0, 1'b0, 8'h00); send(8'h12);
    expect_ev(8'h16, 1'b0, 1'b0, 8'h31); send(8'h16);
    send(8'hF0); expect_ev(8'h12, 1'b1, 1'b0, 8'h00); send(8'h12);
    expect_ev(8'h29, 1'b0, 1'b0, 8'h20); send(8'h29);
    expect_ev(8'h5A, 1'b0, 1'b0, 8'h0D); send(8'h5A);
    expect_ev(8'h66, 1'b0, 1'b0, 8'h08); send(8'h66);
    expect_ev(8'h76, 1'b0, 1'b0, 8'h00); send(8'h76);
    expect_ev(8'h45, 1'b0, 1'b0, 8'h30); send(8'h45);
    expect_ev(8'h4D, 1'b0, 1'b0, 8'h70); send(8'h4D); idle();
    check("specials_count", {24'd0, press_count}, {24'd0, exp_count});

    // E1 discarded; break of other code / other ext leaves key_down
    send(8'hE1); expect_ev(8'h1C, 1'b0, 1'b0, 8'h61); send(8'h1C);
    send(8'hF0); expect_ev(8'h32, 1'b1, 1'b0, 8'h00); send(8'h32); idle();
    check("other_break_down", {31'd0, key_down}, 32'd1);
    send(8'hE0); send(8'hF0); expect_ev(8'h1C, 1'b1, 1'b1, 8'h00); send(8'h1C); idle();
    check("ext_mismatch_down", {31'd0, key_down}, 32'd1);
    send(8'hF0); expect_ev(8'h1C, 1'b1, 1'b0, 8'h00); send(8'h1C); idle();
    check("match_break_down", {31'd0, key_down}, 32'd0);

    // Extended make/break
    send(8'hE0); expect_ev(8'h75, 1'b0, 1'b1, 8'h00); send(8'h75); idle();
    check("ext_make", {22'd0, key_ext, key_down, held_code}, {22'd0, 1'b1, 1'b1, 8'h75});
    send(8'hE0); send(8'hF0); expect_ev(8'h75, 1'b1, 1'b1, 8'h00); send(8'h75); idle();
    check("ext_break_down", {31'd0, key_down}, 32'd0);
    send(8'hE0); expect_ev(8'h12, 1'b0, 1'b1, 8'h00); send(8'h12); idle();
    check("ext_no_shift", {31'd0, shift_on}, 32'd0);
    send(8'hE0); send(8'hF0); expect_ev(8'h12, 1'b1, 1'b1, 8'h00); send(8'h12);
    send(8'hE0); send(8'hE0); expect_ev(8'h75, 1'b0, 1'b1, 8'h00); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'hE0); expect_ev(8'h75, 1'b1, 1'b1, 8'h00); send(8'h75);
    send(8'hF0); send(8'hF0); expect_ev(8'h1C, 1'b1, 1'b0, 8'h00); send(8'h1C);
    send(8'hE0); expect_ev(8'h58, 1'b0, 1'b1, 8'h00); send(8'h58); idle();
    check("ext_no_caps", {31'd0, caps_on}, 32'd0);
    send(8'hE0); send(8'hF0); expect_ev(8'h58, 1'b1, 1'b1, 8'h00); send(8'h58); idle();
    check("ext_count", {23'd0, key_down, press_count}, {23'd0, 1'b0, exp_count});

    // Typematic repeats
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h61); send(8'h1C);
`ifdef PS2_TYPEMATIC_FILTER_EN
    send(8'h1C); send(8'h1C);
`else
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h61); send(8'h1C);
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h61); send(8'h1C);
`endif
    idle();
    check("typematic_count", {24'd0, press_count}, {24'd0, exp_count});
    send(8'hF0); expect_ev(8'h1C, 1'b1, 1'b0, 8'h00); send(8'h1C); idle();

    // Reset after a pending F0
    send(8'hF0); idle();
    @(negedge clk); resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    check("midreset_outputs", {key_valid, key_down, shift_on, caps_on, press_count}, 32'd0);
    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL midreset_queue: observed %0d pending events expected 0", exp_q.size());
    end
    exp_count = 8'h00;
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h61); send(8'h1C); idle();
    check("post_reset_make", {23'd0, key_break, press_count}, {23'd0, 1'b0, exp_count});

    // Counter wrap via 255 back-to-back makes of alternating keys
    for (int i = 0; i < 255; i++) begin
      if (i % 2 == 0) begin
        expect_ev(8'h32, 1'b0, 1'b0, 8'h62); send(8'h32);
      end else begin
        expect_ev(8'h1C, 1'b0, 1'b0, 8'h61); send(8'h1C);
      end
    end
    idle();
    check("count_wrap", {24'd0, press_count}, {24'd0, exp_count});
    check("count_wrap_zero", {24'd0, press_count}, 32'd0);

    repeat (3) @(negedge clk);
    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL missing_events: observed %0d pending events expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
